// File: rtl/sev_seg_scan_driver_pkg.sv
// Shared constants for the seven-segment scan driver.
//   SEG_TABLE : active-low segment codes for hex nibbles 0..F.
//               Bit 7 is dp and is 1 (off). Bits 6:0 are segments g..a.
//   SEG_BLANK : all segments and dp dark.
//   DP_BIT    : position of the decimal point in the seg bus.
package sev_seg_pkg;

    // Packed array: the left-most element is index 15.
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6,   // F E d C
        8'h83, 8'h88, 8'h98, 8'h80,   // b A 9 8
        8'hF8, 8'h82, 8'h92, 8'h99,   // 7 6 5 4
        8'hB0, 8'hA4, 8'hF9, 8'hC0    // 3 2 1 0
    };

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam int         DP_BIT    = 7;

endpackage

// File: rtl/sev_seg_scan_driver_if.sv
// Display bus between a controller and the scan driver.
//   value   : hex nibbles, with nibble i driving digit i.
//   dp_mask : decimal-point request for each digit.
//   load    : capture strobe for value and dp_mask.
//   enable  : when 1, scan the digits; when 0, keep the display dark.
//   seg     : active-low segments, bit 7 = dp.
//   an      : active-low digit enables.
// The master modport is the controller side. The slave modport is the driver.
interface sev_seg_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_mask;
    logic                    load;
    logic                    enable;
    logic [7:0]              seg;
    logic [NUM_DIGITS-1:0]   an;

    modport master (output value, dp_mask, load, enable, input seg, an);
    modport slave  (input value, dp_mask, load, enable, output seg, an);
endinterface

// File: rtl/sev_seg_scan_driver_seg_decode.sv
// Combinational nibble-to-segment decoder.
//   nibble : 4-bit hex digit.
//   seg    : active-low segments g..a. The dp is not included.
module seg_decode
    import sev_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    assign seg = SEG_TABLE[nibble][6:0];
endmodule

// File: rtl/sev_seg_scan_driver.sv
// Time-multiplexed driver for a seven-segment display.
// Each digit is lit for CLK_DIV cycles, then the scan moves to the next digit.
// The display always reads from shadow registers, which are captured on load.
// Leading-zero blanking is optional.
//   clk   : clock.
//   reset : synchronous, active-high reset.
//   bus   : slave side of sev_seg_scan_driver_if, carrying
//           value/dp_mask/load/enable in and seg/an out.
module sev_seg_scan_driver
    import sev_seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int CLK_DIV       = 100000,
    parameter int BLANK_LEADING = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    sev_seg_scan_driver_if.slave   bus
);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRESC_W = $clog2(CLK_DIV);
    // The digit selection arrays are padded to a power of two.
    // This keeps every index value legal.
    localparam int SLOTS   = 1 << IDX_W;

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_MAX   = IDX_W'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] shadow_value_reg;
    logic [NUM_DIGITS-1:0]   shadow_dp_reg;
    logic [PRESC_W-1:0]      presc_reg, presc_next;
    logic [IDX_W-1:0]        idx_reg, idx_next;
    logic [7:0]              seg_reg, seg_next;
    logic [NUM_DIGITS-1:0]   an_reg, an_next;

    logic [3:0] nibble_slot [SLOTS];
    logic       blank_slot  [SLOTS];
    logic       dp_slot     [SLOTS];

    logic [3:0] nibble_sel;
    logic       blank_sel;
    logic       dp_sel;
    logic [6:0] dec_seg;

    // For each digit, gather the nibble, the dp flag and the blank condition.
    // A digit is blanked when it and every more-significant nibble are zero.
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
        if (gi < NUM_DIGITS) begin : g_real
            assign nibble_slot[gi] = shadow_value_reg[4*gi +: 4];
            assign dp_slot[gi]     = shadow_dp_reg[gi];
            if (gi == 0 || BLANK_LEADING == 0) begin : g_noblank
                assign blank_slot[gi] = 1'b0;
            end else begin : g_blank
                assign blank_slot[gi] = ~|shadow_value_reg[4*NUM_DIGITS-1:4*gi];
            end
        end else begin : g_pad
            assign nibble_slot[gi] = 4'h0;
            assign dp_slot[gi]     = 1'b0;
            assign blank_slot[gi]  = 1'b0;
        end
    end

    assign nibble_sel = nibble_slot[idx_reg];
    assign blank_sel  = blank_slot[idx_reg];
    assign dp_sel     = dp_slot[idx_reg];

    seg_decode u_seg_decode (
        .nibble (nibble_sel),
        .seg    (dec_seg)
    );

    // The prescaler and the digit index only move while enable is 1.
    // While enable is 0 they hold, so the dwell resumes where it stopped.
    always_comb begin
        presc_next = presc_reg;
        idx_next   = idx_reg;
        if (bus.enable) begin
            if (presc_reg == PRESC_MAX) begin
                presc_next = '0;
                idx_next   = (idx_reg == IDX_MAX) ? '0 : idx_reg + 1'b1;
            end else begin
                presc_next = presc_reg + 1'b1;
            end
        end
    end

    // Output values are formed from the registered index and shadow contents.
    // A load or wrap on one edge therefore shows up together on the following edge.
    always_comb begin
        seg_next = SEG_BLANK;
        an_next  = '1;
        if (bus.enable) begin
            seg_next[6:0]    = blank_sel ? 7'h7F : dec_seg;
            seg_next[DP_BIT] = ~dp_sel;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                an_next[i] = (IDX_W'(i) != idx_reg);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_value_reg <= '0;
            shadow_dp_reg    <= '0;
            presc_reg        <= '0;
            idx_reg          <= '0;
            seg_reg          <= SEG_BLANK;
            an_reg           <= '1;
        end else begin
            if (bus.load) begin
                shadow_value_reg <= bus.value;
                shadow_dp_reg    <= bus.dp_mask;
            end
            presc_reg <= presc_next;
            idx_reg   <= idx_next;
            seg_reg   <= seg_next;
            an_reg    <= an_next;
        end
    end

    assign bus.seg = seg_reg;
    assign bus.an  = an_reg;

endmodule

// File: doc/sev_seg_scan_driver.md
SEV_SEG_SCAN_DRIVER -- requirements
Module: sev_seg_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 Parameter CLK_DIV, default 100000: clock cycles each digit stays active, minimum 2.
REQ-003 Parameter BLANK_LEADING, default 1: 1 enables leading-zero blanking, 0 disables it.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 value  input  4*NUM_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i; digit 0 is least significant.
REQ-007 dp_mask  input  NUM_DIGITS  bit i = 1 lights the decimal point of digit i.
REQ-008 load  input  1  single-cycle strobe; captures value and dp_mask.
REQ-009 enable  input  1  1 = scan and display; 0 = display dark.
REQ-010 seg  output  8  active-low segments; bit 7 = dp, bits 6:0 = g..a.
REQ-011 an  output  NUM_DIGITS  active-low digit enables; at most one bit low.

Function
REQ-012 On load=1, value and dp_mask SHALL be copied into shadow registers on that edge; the display reads only the shadow registers.
REQ-013 A prescaler SHALL count 0..CLK_DIV-1 and wrap to 0; it advances only while enable=1.
REQ-014 When the prescaler wraps, the digit index SHALL increment, wrapping NUM_DIGITS-1 -> 0.
REQ-015 seg and an SHALL be registered outputs, reflecting the current index and shadow contents one cycle later.
REQ-016 Worst-case load-to-display latency SHALL be 2 cycles for the active digit (shadow update, then output register).
REQ-017 an SHALL drive index bit low and all other bits high (e.g. index 2 of 4 -> 4'b1011).
REQ-018 Nibble encoding (hex, active-low, dp off) SHALL be: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 98, A 88, b 83, C C6, d A1, E 86, F 8E.
REQ-019 If shadow dp bit i = 1, seg bit 7 SHALL be 0 while digit i is active.
REQ-020 With BLANK_LEADING=1, digit i>0 SHALL be blank (seg bits 6:0 all 1) when shadow nibbles i..NUM_DIGITS-1 are all zero; digit 0 is never blanked.
REQ-021 Blanking does not suppress the dp; a blanked digit with its dp bit set SHALL show seg = 7F.
REQ-022 With enable=0, an SHALL be all 1 and seg SHALL be FF from the next cycle; index and prescaler hold their values and resume from them when enable returns to 1.
REQ-023 load is honoured regardless of enable.
REQ-024 load coinciding with a prescaler wrap: both take effect on the same edge; the next output shows the new index with the new shadow data.
REQ-025 load held high for several cycles re-captures on every cycle; the last captured value wins.

Reset
REQ-026 On reset=1: shadow value 0, shadow dp 0, prescaler 0, index 0, seg FF, an all 1, all updated on the next edge.
REQ-027 Reset SHALL take priority over load and enable, including mid-scan; scanning restarts at digit 0 with a full CLK_DIV dwell.

Structure
REQ-028 Package sev_seg_pkg SHALL hold the 16-entry segment code table, SEG_BLANK (FF), and the dp bit position constant.
REQ-029 Nibble-to-segment lookup SHALL be a combinational sub-module seg_decode (4-bit in, 7-bit active-low out), instantiated once on the selected nibble.
REQ-030 Prescaler width SHALL be $clog2(CLK_DIV); index width SHALL be $clog2(NUM_DIGITS), minimum 1.

Verification (NUM_DIGITS=4, CLK_DIV=4, BLANK_LEADING=1 unless stated)
REQ-031 Reset, then load value=12AF, dp=0, enable=1 -> an 1110/1101/1011/0111, each held 4 cycles; seg 8E/88/A4/F9; the sequence repeats.
REQ-032 Load value=0030 -> digits 0..3 show C0, B0, FF, FF; load value=0000 -> C0, FF, FF, FF.
REQ-033 Load value=0030, dp_mask=0110 -> digit1 seg 30, digit2 seg 7F; repeat with BLANK_LEADING=0 -> digit2 seg 40, digit3 seg C0.
REQ-034 enable low for 10 cycles mid-dwell on digit 1 -> an=1111, seg=FF; after re-enable, digit 1 completes its remaining dwell; load during disable is visible on re-enable.
REQ-035 Assert reset for 1 cycle while digit 2 is active with value 12AF loaded -> next cycle an=1111, seg=FF; then digit 0 shows C0 (shadow cleared).
REQ-036 Load 5555 on the exact wrap cycle from digit 0 -> digit 1 immediately shows 92; no stale 12AF nibble appears.
